// File: rtl/uart_result_tx.sv
// uart_result_tx: 8N1 UART transmitter for the CPU debug/result path.
// Result bytes arrive over a valid/ready handshake, are buffered in a small
// FIFO and are sent LSB-first, one start bit, one stop bit, at
// CLKS_PER_BIT clocks per bit. Frames drawn from a non-empty FIFO are
// contiguous, with no idle gap between them.
//
// Ports:
//   clk       core clock, rising edge
//   rst_n     asynchronous reset, active low
//   tx_valid  producer presents a byte on tx_data
//   tx_data   byte to send
//   tx_ready  FIFO can accept a byte (combinational, count != FIFO_DEPTH)
//   tx        registered serial line, idle high
//   busy      registered; high while a frame is in flight or the FIFO holds data
//   overflow  high in any cycle where tx_valid is refused (byte dropped)
module uart_result_tx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n, busy_n;
  logic          bit_tick;
  logic          push, pop;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;

  assign tx_ready = (count != FULL);
  assign push     = tx_valid && tx_ready;
  assign overflow = tx_valid && !tx_ready;
  assign bit_tick = (baud == BAUD_LAST);

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  always_comb begin
    state_n = state;
    baud_n  = bit_tick ? '0 : baud + BW'(1);
    idx_n   = idx;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (count != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
        end
      end
      START: begin
        if (bit_tick) begin
          state_n = DATA;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_n = {1'b0, shift[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          // Chain straight into the next start bit so frames stay contiguous.
          if (count != '0) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
    endcase

    // tx and busy are registered from next-state values so the line
    // changes exactly on the edge where the FSM changes.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE) || (count_n != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      baud   <= '0;
      idx    <= '0;
      shift  <= '0;
      tx     <= 1'b1;
      busy   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_n;
      baud  <= baud_n;
      idx   <= idx_n;
      shift <= shift_n;
      tx    <= tx_n;
      busy  <= busy_n;
      count <= count_n;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

endmodule

// File: tb/tb_uart_result_tx.sv
// Testbench for uart_result_tx with CLKS_PER_BIT=16, FIFO_DEPTH=4.
// A frame-level model (byte queue plus position within the current frame)
// predicts tx/busy/tx_ready/overflow every cycle; a mid-bit decoder turns
// the line back into bytes that are compared to hand-written lists.
module tb_uart_result_tx;
  localparam int N = 16;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx, busy, overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int ovf_seen = 0;

  always #5 clk = ~clk;

  uart_result_tx #(.CLKS_PER_BIT(N), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .overflow(overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  byte unsigned mq[$];
  logic         m_active = 1'b0;
  int           m_pos = 0;
  logic [7:0]   m_cur = 8'h00;
  int           m_pre;
  logic         m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_active = 1'b0;
      m_pos    = 0;
    end else begin
      m_pre = mq.size();
      m_acc = tx_valid && (m_pre != D);
      if (m_active) begin
        m_pos++;
        if (m_pos == 10 * N) begin
          if (m_pre != 0) begin
            m_cur = mq.pop_front();
            m_pos = 0;
          end else begin
            m_active = 1'b0;
          end
        end
      end else if (m_pre != 0) begin
        m_cur    = mq.pop_front();
        m_pos    = 0;
        m_active = 1'b1;
      end
      if (m_acc) mq.push_back(tx_data);
    end
  end

  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / N;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  always @(negedge clk) begin
    chk("tx", tx, exp_tx());
    chk("busy", busy, m_active || (mq.size() != 0));
    chk("tx_ready", tx_ready, mq.size() != D);
    chk("overflow", overflow, tx_valid && (mq.size() == D));
    if (overflow) ovf_seen++;
  end

  // ---------------- mid-bit decoder ----------------
  logic         d_act = 1'b0;
  int           d_cnt = 0;
  logic [7:0]   d_byte = 8'h00;
  byte unsigned dq[$];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_act = 1'b0;
      d_cnt = 0;
    end else if (!d_act) begin
      if (tx == 1'b0) begin
        d_act = 1'b1;
        d_cnt = 0;
      end
    end else begin
      d_cnt++;
      if (d_cnt % N == N / 2) begin
        if (d_cnt / N == 0) chk("start_bit", tx, 0);
        else if (d_cnt / N <= 8) d_byte[d_cnt / N - 1] = tx;
        else begin
          chk("stop_bit", tx, 1);
          dq.push_back(d_byte);
          d_act = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  byte unsigned eq[$];

  task automatic check_dq(input string name);
    chk($sformatf("%s_count", name), dq.size(), eq.size());
    for (int i = 0; i < eq.size() && i < dq.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), dq[i], eq[i]);
    dq.delete();
  endtask

  task automatic wait_idle(input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!busy && !d_act) break;
    end
    if (i == maxc) chk("idle_timeout_busy", busy, 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("idle_tx", tx, 1);
    chk("idle_busy", busy, 0);

    // single byte 0xA5
    tx_valid = 1'b1; tx_data = 8'hA5;
    @(posedge clk); #1 tx_valid = 1'b0;
    chk("a5_push_tx", tx, 1);
    chk("a5_push_busy", busy, 1);
    @(posedge clk); #1;
    chk("a5_start_tx", tx, 0);
    repeat (159) @(posedge clk); #1;
    chk("a5_last_busy", busy, 1);
    chk("a5_last_tx", tx, 1);
    @(posedge clk); #1;
    chk("a5_done_busy", busy, 0);
    wait_idle(50);
    eq = '{8'hA5};
    check_dq("single");

    // back-to-back 0x55, 0x0F
    tx_valid = 1'b1; tx_data = 8'h55;
    @(posedge clk); #1 tx_data = 8'h0F;
    @(posedge clk); #1 tx_valid = 1'b0;
    wait_idle(500);
    eq = '{8'h55, 8'h0F};
    check_dq("b2b");

    // full / overflow: 0x01..0x06 on consecutive cycles
    ovf_seen = 0;
    for (int i = 1; i <= 6; i++) begin
      tx_valid = 1'b1; tx_data = 8'(i);
      if (i == 6) begin
        #1;
        chk("full_tx_ready", tx_ready, 0);
        chk("full_overflow", overflow, 1);
      end
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    wait_idle(1200);
    chk("ovf_pulses", ovf_seen, 1);
    eq.delete();
    for (int i = 1; i <= 5; i++) eq.push_back(8'(i));
    check_dq("full");

    // reset during data bit 3 of 0x3C
    tx_valid = 1'b1; tx_data = 8'h3C;
    @(posedge clk); #1 tx_valid = 1'b0;
    repeat (1 + 4 * N + 8) @(posedge clk);
    #3;
    chk("mid_busy", busy, 1);
    chk("mid_bit3", tx, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", tx_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("post_rst_tx", tx, 1);
    tx_valid = 1'b1; tx_data = 8'h81;
    @(posedge clk); #1 tx_valid = 1'b0;
    wait_idle(400);
    eq = '{8'h81};
    check_dq("after_rst");

    // pointer wrap: 10 spaced bytes
    ovf_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tx_valid = 1'b1; tx_data = 8'(8'h10 + i);
      @(posedge clk); #1 tx_valid = 1'b0;
      repeat (150) @(posedge clk); #1;
    end
    wait_idle(2000);
    chk("wrap_no_overflow", ovf_seen, 0);
    eq.delete();
    for (int i = 0; i < 10; i++) eq.push_back(8'(8'h10 + i));
    check_dq("wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_result_tx.md
Name: uart_result_tx

Overview:
UART transmitter for the debug/result path of the pipelined CPU. It is the send side of the link whose receive side feeds uart_rx_data into the register file. It accepts result bytes from the register-file result port via a valid/ready handshake and buffers them in a small FIFO. Bytes are serialized as 8N1 frames (1 start, 8 data LSB-first, 1 stop) on the tx line at a fixed baud rate derived from the core clock.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud); must be >= 2
FIFO_DEPTH, 4, byte entries in transmit buffer; power of two, >= 2

Ports:
clk  input  1  core clock, rising-edge
rst_n  input  1  asynchronous reset, active-low
tx_valid  input  1  producer has a byte on tx_data
tx_data  input  8  byte to send (e.g. uart_result_data)
tx_ready  output  1  FIFO can accept; combinational, = (count != FIFO_DEPTH)
tx  output  1  serial line, idle high
busy  output  1  high while a frame is in progress or FIFO non-empty
overflow  output  1  one-cycle pulse when tx_valid=1 and tx_ready=0 (byte dropped)

Behaviour:
- Reset (async, rst_n=0): tx=1, busy=0, overflow=0, FIFO empty (count=0, pointers 0), FSM=IDLE, baud counter=0, bit index=0. tx_ready=1. Applies immediately, including mid-frame: line returns high and the partial frame is abandoned.
- Push: on a rising edge with tx_valid && tx_ready, tx_data is written at the write pointer and count increments. The pointer wraps modulo FIFO_DEPTH.
- Full: tx_ready=0. A push is refused even if a pop happens in the same cycle. A refused tx_valid raises overflow for that cycle and the data is discarded.
- Simultaneous push and pop (not full): both occur and count is unchanged.
- FSM states: IDLE, START, DATA, STOP. Baud counter counts 0..CLKS_PER_BIT-1; bit_tick marks the last count.
- IDLE: tx=1. If count != 0 at an edge: pop the head byte into the shift register, enter START, and clear the baud counter. A byte pushed at edge k into an empty FIFO drives tx low after edge k+1.
- START: tx=0 for CLKS_PER_BIT cycles. On bit_tick go to DATA with bit index 0.
- DATA: tx=shift[0]. On bit_tick, shift right and increment the index. After the 8th bit_tick go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. On bit_tick:
  - if count != 0: pop and go directly to START, with no idle gap;
  - else go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- tx is a registered output, so there are no glitches.
- busy is registered: 1 whenever FSM != IDLE or count != 0.
- Data order is FIFO. Bytes are never reordered or duplicated.

Test Plan:
- Reset values: with CLKS_PER_BIT=16, hold rst_n=0 → tx=1, busy=0, tx_ready=1, overflow=0. Release and idle 100 cycles → tx stays 1.
- Single byte: push 0xA5 at edge k → tx falls after edge k+1. The line then carries 0 for 16 cycles, then bits 1,0,1,0,0,1,0,1, each 16 cycles, then 1 for 16 cycles. busy drops after 160 cycles.
- Back-to-back: push 0x55 and 0x0F on consecutive cycles → two 160-cycle frames with no idle cycle between the stop bit of 0x55 and the start bit of 0x0F. The bench samples mid-bit and decodes 0x55 then 0x0F.
- Full/overflow: FIFO_DEPTH=4, push 6 bytes 0x01..0x06 on consecutive cycles.
  - Byte 1 pops at the next edge, so 0x01..0x05 are accepted.
  - At 0x06, tx_ready=0 and overflow pulses once.
  - Decoded output is 0x01..0x05 only.
- Reset mid-frame: assert rst_n=0 during data bit 3 of 0x3C → tx=1 immediately and busy=0. After release, push 0x81 → a clean frame with 0x81 is decoded.
- Pointer wrap: push 10 bytes 0x10..0x19, each timed so the FIFO never fills → all 10 are decoded in order and overflow never asserts.
